wb_timer_sched: RTL and testbench

Multiplexes the single memory-mapped machine timer among `N_CH` hardware requesters, each owning one 64-bit absolute deadline slot. It is a Wishbone master on the timer's slave port. It reads `mtime`, retires expired slots with a one-cycle `expired_o` pulse, and programs `mtimecmp` with the earliest remaining deadline. It re-runs on every arm/cancel and on every timer IRQ.

---
 rtl/timer_sched_pkg.sv | 27 ++
 rtl/timer_sched_wbm.sv | 53 +++++
 rtl/wb_timer_sched.sv | 204 ++++++++++++++++++++
 tb/tb_wb_timer_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the deadline scheduler: FSM states,
// timer register offsets, the "never" deadline and the IRQ settle length.
package timer_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_HI0,
    ST_RD_LO,
    ST_RD_HI1,
    ST_CHECK,
    ST_SCAN,
    ST_WR_LO_MAX,
    ST_WR_HI,
    ST_WR_LO,
    ST_SETTLE
  } state_t;

  localparam logic [31:0] OFF_MTIME_LO    = 32'h0;
  localparam logic [31:0] OFF_MTIME_HI    = 32'h4;
  localparam logic [31:0] OFF_MTIMECMP_LO = 32'h8;
  localparam logic [31:0] OFF_MTIMECMP_HI = 32'hC;

  localparam logic [63:0] NEVER = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/timer_sched_wbm.sv
// Single-transfer Wishbone master: a start pulse launches one read or write,
// done pulses in the ack cycle so the caller can chain the next transfer there.
module timer_sched_wbm #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] wbm_addr_o,
  output logic [DW-1:0] wbm_data_o,
  output logic          wbm_we_o,
  output logic [SW-1:0] wbm_sel_o,
  output logic          wbm_stb_o,
  output logic          wbm_cyc_o,
  input  logic          wbm_ack_i,
  input  logic [DW-1:0] wbm_data_i
);

  assign done  = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
  assign rdata = wbm_data_i;

  // A start in the ack cycle takes priority so back-to-back transfers keep cyc high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_addr_o <= '0;
      wbm_data_o <= '0;
      wbm_sel_o  <= '0;
    end else begin
      wbm_sel_o <= '1;
      if (start) begin
        wbm_cyc_o  <= 1'b1;
        wbm_stb_o  <= 1'b1;
        wbm_we_o   <= we;
        wbm_addr_o <= addr;
        wbm_data_o <= wdata;
      end else if (done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_timer_sched.sv
// Shares one machine timer among N_CH absolute-deadline slots: reads mtime,
// retires expired slots, then programs mtimecmp with the earliest remaining deadline.
module wb_timer_sched
  import timer_sched_pkg::*;
#(
  parameter int                  N_CH          = 4,
  parameter int                  WB_DATA_WIDTH = 32,
  parameter int                  WB_ADDR_WIDTH = 32,
  parameter int                  WB_SEL_WIDTH  = 4,
  parameter logic [WB_ADDR_WIDTH-1:0] TIMER_BASE = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_valid_i,
  input  logic [N_CH-1:0]          req_cancel_i,
  input  logic [64*N_CH-1:0]       req_deadline_i,
  output logic                     req_ready_o,
  output logic [N_CH-1:0]          expired_o,
  output logic [N_CH-1:0]          armed_o,
  output logic                     busy_o,
  input  logic                     timer_irq_i,
  output logic [WB_ADDR_WIDTH-1:0] wbm_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wbm_data_o,
  output logic                     wbm_we_o,
  output logic [WB_SEL_WIDTH-1:0]  wbm_sel_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_cyc_o,
  input  logic                     wbm_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wbm_data_i
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t                   state;
  logic [63:0]              dl [N_CH];
  logic [31:0]              hi0;
  logic [31:0]              lo;
  logic [63:0]              tgt;
  logic [63:0]              now;
  logic [IW-1:0]            idx;
  logic [1:0]               settle_cnt;
  logic [N_CH-1:0]          due;
  logic                     go;
  logic                     last_scan;
  logic                     hi_match;
  logic                     wb_start;
  logic                     wb_we;
  logic                     wb_done;
  logic [WB_ADDR_WIDTH-1:0] wb_addr;
  logic [WB_DATA_WIDTH-1:0] wb_wdata;
  logic [WB_DATA_WIDTH-1:0] wb_rdata;

  assign now       = {hi0, lo};
  assign go        = req_ready_o && ((|(req_valid_i | req_cancel_i)) || timer_irq_i);
  assign last_scan = (idx == IW'(N_CH - 1));
  assign hi_match  = (wb_rdata[31:0] == hi0);

  always_comb begin
    due = '0;
    for (int i = 0; i < N_CH; i++) due[i] = armed_o[i] && (dl[i] <= now);
  end

  // Each transfer is launched in the cycle the previous one is acked, so the
  // bus sees no idle cycle between the reads or between the writes.
  always_comb begin
    wb_start = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIME_HI);
    wb_wdata = '0;
    case (state)
      ST_IDLE:   wb_start = go;
      ST_RD_HI0: begin
        wb_start = wb_done;
        wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIME_LO);
      end
      ST_RD_LO:  wb_start = wb_done;
      ST_RD_HI1: begin
        wb_start = wb_done && !hi_match;
        wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIME_LO);
      end
      ST_SCAN: begin
        wb_start = last_scan;
        wb_we    = 1'b1;
        wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIMECMP_LO);
        wb_wdata = '1;
      end
      ST_WR_LO_MAX: begin
        wb_start = wb_done;
        wb_we    = 1'b1;
        wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIMECMP_HI);
        wb_wdata = WB_DATA_WIDTH'(tgt[63:32]);
      end
      ST_WR_HI: begin
        wb_start = wb_done;
        wb_we    = 1'b1;
        wb_addr  = TIMER_BASE + WB_ADDR_WIDTH'(OFF_MTIMECMP_LO);
        wb_wdata = WB_DATA_WIDTH'(tgt[31:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      armed_o     <= '0;
      expired_o   <= '0;
      req_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      hi0         <= '0;
      lo          <= '0;
      tgt         <= NEVER;
      idx         <= '0;
      settle_cnt  <= '0;
      for (int i = 0; i < N_CH; i++) dl[i] <= '0;
    end else begin
      expired_o <= '0;
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (go) begin
            for (int i = 0; i < N_CH; i++) begin
              if (req_valid_i[i]) begin
                dl[i]      <= req_deadline_i[64*i +: 64];
                armed_o[i] <= 1'b1;
              end else if (req_cancel_i[i]) begin
                armed_o[i] <= 1'b0;
              end
            end
            state       <= ST_RD_HI0;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        ST_RD_HI0: if (wb_done) begin
          hi0   <= wb_rdata[31:0];
          state <= ST_RD_LO;
        end
        ST_RD_LO: if (wb_done) begin
          lo    <= wb_rdata[31:0];
          state <= ST_RD_HI1;
        end
        // HI1 becomes the reference high word whether or not the halves matched.
        ST_RD_HI1: if (wb_done) begin
          hi0   <= wb_rdata[31:0];
          state <= hi_match ? ST_CHECK : ST_RD_LO;
        end
        ST_CHECK: begin
          armed_o   <= armed_o & ~due;
          expired_o <= due;
          idx       <= '0;
          tgt       <= NEVER;
          state     <= ST_SCAN;
        end
        ST_SCAN: begin
          if (armed_o[idx] && (dl[idx] < tgt)) tgt <= dl[idx];
          if (last_scan) state <= ST_WR_LO_MAX;
          else           idx   <= idx + 1'b1;
        end
        ST_WR_LO_MAX: if (wb_done) state <= ST_WR_HI;
        ST_WR_HI:     if (wb_done) state <= ST_WR_LO;
        ST_WR_LO: if (wb_done) begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        // The timer's IRQ register still reflects the old compare value here.
        ST_SETTLE: begin
          if (settle_cnt == 2'(SETTLE_CYCLES - 1)) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  timer_sched_wbm #(
    .DW(WB_DATA_WIDTH),
    .AW(WB_ADDR_WIDTH),
    .SW(WB_SEL_WIDTH)
  ) u_wbm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start      (wb_start),
    .we         (wb_we),
    .addr       (wb_addr),
    .wdata      (wb_wdata),
    .done       (wb_done),
    .rdata      (wb_rdata),
    .wbm_addr_o (wbm_addr_o),
    .wbm_data_o (wbm_data_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_data_i (wbm_data_i)
  );

endmodule

// File: tb/tb_wb_timer_sched.sv
// Directed bench for wb_timer_sched with a behavioural mtime/mtimecmp slave
// (registered ack, registered IRQ level).
module tb_wb_timer_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_cancel;
  logic [255:0] req_deadline;
  logic         req_ready;
  logic [3:0]   expired;
  logic [3:0]   armed;
  logic         busy;
  logic         timer_irq;
  logic [31:0]  wbm_addr;
  logic [31:0]  wbm_dat_w;
  logic         wbm_we;
  logic [3:0]   wbm_sel;
  logic         wbm_stb;
  logic         wbm_cyc;
  logic         wbm_ack;
  logic [31:0]  wbm_dat_r;

  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  logic         s_irq;
  logic         irq_force;
  logic         mt_load;
  logic [63:0]  mt_load_val;
  logic         tick;

  int compared = 0;
  int failed   = 0;
  int cyc_cnt  = 0;
  int rd_cnt   = 0;
  int exp_pulses = 0;
  logic [31:0] wl_addr[$];
  logic [31:0] wl_data[$];
  int          wl_cyc[$];

  wb_timer_sched dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_cancel_i(req_cancel), .req_deadline_i(req_deadline),
    .req_ready_o(req_ready), .expired_o(expired), .armed_o(armed), .busy_o(busy),
    .timer_irq_i(timer_irq),
    .wbm_addr_o(wbm_addr), .wbm_data_o(wbm_dat_w), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
    .wbm_stb_o(wbm_stb), .wbm_cyc_o(wbm_cyc), .wbm_ack_i(wbm_ack), .wbm_data_i(wbm_dat_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign timer_irq = s_irq | irq_force;

  // Timer slave model
  always @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      wbm_ack  <= 1'b0;
      s_irq    <= 1'b0;
      wbm_dat_r <= '0;
    end else begin
      if (mt_load) mtime <= mt_load_val;
      else if (tick) mtime <= mtime + 64'd1;
      wbm_ack <= wbm_cyc && wbm_stb && !wbm_ack;
      if (wbm_cyc && wbm_stb && !wbm_ack) begin
        if (wbm_we) begin
          if (wbm_addr[3:0] == 4'h8) mtimecmp[31:0]  <= wbm_dat_w;
          if (wbm_addr[3:0] == 4'hC) mtimecmp[63:32] <= wbm_dat_w;
        end else begin
          wbm_dat_r <= (wbm_addr[3:0] == 4'h4) ? mtime[63:32] : mtime[31:0];
        end
      end
      s_irq <= (mtime >= mtimecmp);
    end
  end

  always @(negedge clk) begin
    if (wbm_cyc && wbm_ack && wbm_we) begin
      wl_addr.push_back(wbm_addr);
      wl_data.push_back(wbm_dat_w);
      wl_cyc.push_back(cyc_cnt);
    end
    if (wbm_cyc && wbm_ack && !wbm_we) rd_cnt = rd_cnt + 1;
    if (|expired) exp_pulses = exp_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_dl(input int s, input logic [63:0] v);
    req_deadline[64*s +: 64] = v;
  endtask

  task automatic load_mtime(input logic [63:0] v);
    mt_load_val = v;
    mt_load = 1'b1;
    @(negedge clk);
    mt_load = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_idle_timeout: busy=%b expected 0", nm, busy);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++; if (req_ready !== 1'b0) begin failed++; $display("FAIL rst_ready: got %b expected 0", req_ready); end
    compared++; if ({busy, armed, expired} !== 9'd0) begin failed++; $display("FAIL rst_status: got %b expected 0", {busy, armed, expired}); end
    compared++; if ({wbm_cyc, wbm_stb, wbm_we} !== 3'd0) begin failed++; $display("FAIL rst_bus_ctl: got %b expected 000", {wbm_cyc, wbm_stb, wbm_we}); end
    compared++; if ({wbm_addr, wbm_dat_w, wbm_sel} !== 68'd0) begin failed++; $display("FAIL rst_bus_dat: got %h expected 0", {wbm_addr, wbm_dat_w, wbm_sel}); end
    rst = 1'b0;
    @(negedge clk);
    compared++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL rst_release: ready=%b busy=%b expected 1/0", req_ready, busy); end
  endtask

  task automatic test_reset_mid;
    set_dl(0, 64'd1000);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    compared++; if ({wbm_cyc, wbm_stb, wbm_we} !== 3'b110) begin failed++; $display("FAIL mid_bus_active: got %b expected 110", {wbm_cyc, wbm_stb, wbm_we}); end
    compared++; if (wbm_addr !== 32'h4 || wbm_sel !== 4'hF) begin failed++; $display("FAIL mid_addr_sel: addr=%h sel=%h expected 4/F", wbm_addr, wbm_sel); end
    compared++; if (armed !== 4'b0001) begin failed++; $display("FAIL mid_armed: got %b expected 0001", armed); end
    rst = 1'b1;
    #1;
    compared++; if ({wbm_cyc, wbm_stb} !== 2'b00 || armed !== 4'd0) begin failed++; $display("FAIL mid_reset_drop: cyc/stb=%b armed=%b expected 00/0000", {wbm_cyc, wbm_stb}, armed); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL mid_idle_after: ready=%b busy=%b expected 1/0", req_ready, busy); end
  endtask

  task automatic test_expire_now;
    int n0, t0;
    logic [31:0] ea [3];
    ea[0] = 32'h8; ea[1] = 32'hC; ea[2] = 32'h8;
    load_mtime(64'd100);
    n0 = wl_addr.size();
    t0 = cyc_cnt;
    set_dl(1, 64'd50);
    req_valid = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 4'b0000;
        compared++; if (armed !== 4'b0010) begin failed++; $display("FAIL now_armed: got %b expected 0010", armed); end
      end
      if (k == 7) begin compared++; if (expired !== 4'b0000) begin failed++; $display("FAIL now_exp_c7: got %b expected 0000", expired); end end
      if (k == 8) begin compared++; if (expired !== 4'b0010) begin failed++; $display("FAIL now_exp_c8: got %b expected 0010", expired); end end
      if (k == 9) begin compared++; if ({expired, armed} !== 8'd0) begin failed++; $display("FAIL now_c9: exp/armed=%b expected 0", {expired, armed}); end end
      if (k == 19) begin compared++; if (req_ready !== 1'b0) begin failed++; $display("FAIL now_ready_c19: got %b expected 0", req_ready); end end
      if (k == 20) begin compared++; if (req_ready !== 1'b1) begin failed++; $display("FAIL now_ready_c20: got %b expected 1", req_ready); end end
    end
    compared++;
    if (wl_addr.size() - n0 !== 3) begin
      failed++; $display("FAIL now_wr_count: got %0d expected 3", wl_addr.size() - n0);
    end else begin
      for (int j = 0; j < 3; j++) begin
        compared++;
        if (wl_addr[n0+j] !== ea[j] || wl_data[n0+j] !== 32'hFFFF_FFFF) begin
          failed++; $display("FAIL now_wr%0d: got %h=%h expected %h=ffffffff", j, wl_addr[n0+j], wl_data[n0+j], ea[j]);
        end
      end
      compared++; if (wl_cyc[n0+2] - t0 !== 17) begin failed++; $display("FAIL now_last_ack: cycle %0d expected 17", wl_cyc[n0+2] - t0); end
    end
  endtask

  task automatic test_cancel;
    int e0;
    set_dl(3, 64'd500);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = 4'b0000;
    wait_idle("cancel_arm");
    compared++; if (armed !== 4'b1000 || mtimecmp !== 64'd500) begin failed++; $display("FAIL cancel_pre: armed=%b cmp=%h expected 1000/1f4", armed, mtimecmp); end
    e0 = exp_pulses;
    req_cancel = 4'b1000;
    @(negedge clk);
    req_cancel = 4'b0000;
    compared++; if (armed !== 4'b0000) begin failed++; $display("FAIL cancel_armed: got %b expected 0000", armed); end
    wait_idle("cancel");
    compared++; if (exp_pulses !== e0) begin failed++; $display("FAIL cancel_no_pulse: got %0d pulses expected 0", exp_pulses - e0); end
    compared++; if (mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("FAIL cancel_cmp: got %h expected all-ones", mtimecmp); end
    set_dl(0, 64'd1000);
    req_valid = 4'b0001;
    req_cancel = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    req_cancel = 4'b0000;
    compared++; if (armed !== 4'b0001) begin failed++; $display("FAIL arm_wins: got %b expected 0001", armed); end
    wait_idle("arm_wins");
    compared++; if (mtimecmp !== 64'd1000) begin failed++; $display("FAIL arm_wins_cmp: got %h expected 3e8", mtimecmp); end
    req_cancel = 4'b0001;
    @(negedge clk);
    req_cancel = 4'b0000;
    wait_idle("cleanup");
  endtask

  task automatic test_two_slots;
    int n0, t0, k;
    n0 = wl_addr.size();
    t0 = cyc_cnt;
    set_dl(0, 64'd150);
    set_dl(2, 64'd120);
    req_valid = 4'b0101;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 4'b0000;
        compared++; if (armed !== 4'b0101) begin failed++; $display("FAIL two_armed: got %b expected 0101", armed); end
      end
      if (c == 8) begin compared++; if (expired !== 4'b0000) begin failed++; $display("FAIL two_no_exp: got %b expected 0000", expired); end end
      if (c == 20) begin compared++; if (req_ready !== 1'b1) begin failed++; $display("FAIL two_ready_c20: got %b expected 1", req_ready); end end
    end
    compared++;
    if (wl_addr.size() - n0 !== 3) begin
      failed++; $display("FAIL two_wr_count: got %0d expected 3", wl_addr.size() - n0);
    end else begin
      compared++; if (wl_addr[n0] !== 32'h8 || wl_data[n0] !== 32'hFFFF_FFFF) begin failed++; $display("FAIL two_wr0: got %h=%h expected 8=ffffffff", wl_addr[n0], wl_data[n0]); end
      compared++; if (wl_addr[n0+1] !== 32'hC || wl_data[n0+1] !== 32'h0) begin failed++; $display("FAIL two_wr1: got %h=%h expected c=0", wl_addr[n0+1], wl_data[n0+1]); end
      compared++; if (wl_addr[n0+2] !== 32'h8 || wl_data[n0+2] !== 32'd120) begin failed++; $display("FAIL two_wr2: got %h=%h expected 8=78", wl_addr[n0+2], wl_data[n0+2]); end
      compared++; if (wl_cyc[n0+2] - t0 !== 17) begin failed++; $display("FAIL two_last_ack: cycle %0d expected 17", wl_cyc[n0+2] - t0); end
    end
    load_mtime(64'd120);
    k = 0;
    while (expired === 4'b0000 && k < 60) begin
      @(negedge clk);
      k++;
    end
    compared++; if (expired !== 4'b0100) begin failed++; $display("FAIL two_irq_exp: got %b expected 0100", expired); end
    wait_idle("two_irq");
    compared++; if (mtimecmp !== 64'd150 || armed !== 4'b0001) begin failed++; $display("FAIL two_reprog: cmp=%h armed=%b expected 96/0001", mtimecmp, armed); end
  endtask

  task automatic test_back_to_back;
    req_cancel = 4'b0001;
    @(negedge clk);
    req_cancel = 4'b0000;
    set_dl(1, 64'd400);
    req_valid = 4'b0010;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (k == 10) begin compared++; if (armed !== 4'b0000) begin failed++; $display("FAIL held_ignored: armed=%b expected 0000", armed); end end
      if (k == 20) begin compared++; if (req_ready !== 1'b1) begin failed++; $display("FAIL held_ready_c20: got %b expected 1", req_ready); end end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    compared++; if ({req_ready, busy, armed} !== 6'b010010) begin failed++; $display("FAIL held_accept: ready/busy/armed=%b expected 010010", {req_ready, busy, armed}); end
    wait_idle("held");
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b0 || mtimecmp !== 64'd400) begin failed++; $display("FAIL held_once: busy=%b cmp=%h expected 0/190", busy, mtimecmp); end
  endtask

  task automatic test_settle_irq;
    set_dl(2, 64'd1000);
    req_valid = 4'b0100;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 4'b0000;
      if (k == 18) irq_force = 1'b1;
      if (k == 20) begin
        compared++; if (req_ready !== 1'b1) begin failed++; $display("FAIL settle_ready_c20: got %b expected 1", req_ready); end
        irq_force = 1'b0;
      end
      if (k >= 21) begin compared++; if (busy !== 1'b0) begin failed++; $display("FAIL settle_stale_irq_c%0d: busy=%b expected 0", k, busy); end end
    end
    compared++; if (mtimecmp !== 64'd400 || armed !== 4'b0110) begin failed++; $display("FAIL settle_state: cmp=%h armed=%b expected 190/0110", mtimecmp, armed); end
  endtask

  task automatic test_rollover;
    int r0;
    r0 = rd_cnt;
    set_dl(0, 64'h1_0000_0000);
    req_valid = 4'b0001;
    mt_load_val = 64'h0000_0000_FFFF_FFFF;
    mt_load = 1'b1;
    tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid = 4'b0000; mt_load = 1'b0; end
      if (k == 8) begin compared++; if (expired !== 4'b0000) begin failed++; $display("FAIL roll_no_early_check: got %b expected 0000", expired); end end
      if (k == 12) begin compared++; if (expired !== 4'b0111) begin failed++; $display("FAIL roll_exp_c12: got %b expected 0111", expired); end end
    end
    wait_idle("roll");
    tick = 1'b0;
    compared++; if (rd_cnt - r0 !== 5) begin failed++; $display("FAIL roll_reads: got %0d expected 5", rd_cnt - r0); end
    compared++; if (armed !== 4'b0000 || mtimecmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("FAIL roll_final: armed=%b cmp=%h expected 0/all-ones", armed, mtimecmp); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_valid = '0;
    req_cancel = '0;
    req_deadline = '0;
    irq_force = 1'b0;
    mt_load = 1'b0;
    mt_load_val = '0;
    tick = 1'b0;
    test_reset;
    test_reset_mid;
    test_expire_now;
    test_cancel;
    test_two_slots;
    test_back_to_back;
    test_settle_irq;
    test_rollover;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
